// File: rtl/laser_pulse_monitor.sv
// Receive-side checker for the laser-timer enable X. It measures each high pulse,
// grades it against EXP_WIDTH, counts pulses and errors, and latches a stuck-on fault.
module laser_pulse_monitor #(
  parameter int EXP_WIDTH = 3,
  parameter int MAX_ON    = 8,
  parameter int CNT_W     = 4,
  parameter int PC_W      = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             X,
  input  logic             Clr,
  output logic [CNT_W-1:0] Width,
  output logic             Done,
  output logic             Ok,
  output logic             Stuck,
  output logic [PC_W-1:0]  PulseCnt,
  output logic [PC_W-1:0]  ErrCnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HIGH  = 2'd1;
  localparam logic [1:0] STUCK = 2'd2;

  localparam logic [CNT_W:0]   MAX_ON_V = (CNT_W+1)'(MAX_ON);
  localparam logic [CNT_W-1:0] EXP_V    = CNT_W'(EXP_WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so the overflow comparison cannot wrap.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      Width    <= '0;
      Done     <= 1'b0;
      Ok       <= 1'b0;
      Stuck    <= 1'b0;
      PulseCnt <= '0;
      ErrCnt   <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (X) begin
            cnt   <= CNT_W'(1);
            state <= HIGH;
          end
          if (Clr) begin
            PulseCnt <= '0;
            ErrCnt   <= '0;
          end
        end

        HIGH: begin
          if (X) begin
            if (cnt_inc > MAX_ON_V) begin
              state <= STUCK;
              Stuck <= 1'b1;
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
            if (Clr) begin
              PulseCnt <= '0;
              ErrCnt   <= '0;
            end
          end else begin
            Width <= cnt;
            Done  <= 1'b1;
            Ok    <= (cnt == EXP_V);
            cnt   <= '0;
            state <= IDLE;
            // A clear on the pulse-end edge overrides the count of that pulse.
            if (Clr) begin
              PulseCnt <= '0;
              ErrCnt   <= '0;
            end else begin
              PulseCnt <= PulseCnt + PC_W'(1);
              if (cnt != EXP_V && ErrCnt != '1)
                ErrCnt <= ErrCnt + PC_W'(1);
            end
          end
        end

        STUCK: begin
          // Leaving the fault needs the laser off and an explicit clear.
          if (!X && Clr) begin
            state    <= IDLE;
            Stuck    <= 1'b0;
            cnt      <= '0;
            PulseCnt <= '0;
            ErrCnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_pulse_monitor.sv
// Directed bench for laser_pulse_monitor with hand-computed expectations.
module tb_laser_pulse_monitor;

  logic       Clk;
  logic       Rst;
  logic       X;
  logic       Clr;
  logic [3:0] Width;
  logic       Done;
  logic       Ok;
  logic       Stuck;
  logic [7:0] PulseCnt;
  logic [7:0] ErrCnt;

  int n_checks;
  int n_errors;

  laser_pulse_monitor #(
    .EXP_WIDTH(3), .MAX_ON(8), .CNT_W(4), .PC_W(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .X(X), .Clr(Clr),
    .Width(Width), .Done(Done), .Ok(Ok), .Stuck(Stuck),
    .PulseCnt(PulseCnt), .ErrCnt(ErrCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1 time unit past it.
  task automatic cycle(input logic x, input logic clr);
    X   = x;
    Clr = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input int len);
    for (int i = 0; i < len; i++) cycle(1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_width"}, 32'(Width), 32'd0);
    check({tag, "_done"},  32'(Done), 32'd0);
    check({tag, "_ok"},    32'(Ok), 32'd0);
    check({tag, "_stuck"}, 32'(Stuck), 32'd0);
    check({tag, "_pcnt"},  32'(PulseCnt), 32'd0);
    check({tag, "_ecnt"},  32'(ErrCnt), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // 1: reset with X high, then idle low
    Rst = 1'b0;
    X   = 1'b1;
    Clr = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_all_zero("rst");
    Rst = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("idle_done", 32'(Done), 32'd0);

    // 2: nominal 3-cycle pulse
    pulse(3);
    check("p3_done_early", 32'(Done), 32'd0);
    cycle(1'b0, 1'b0);
    check("p3_done", 32'(Done), 32'd1);
    check("p3_width", 32'(Width), 32'd3);
    check("p3_ok", 32'(Ok), 32'd1);
    check("p3_pcnt", 32'(PulseCnt), 32'd1);
    check("p3_ecnt", 32'(ErrCnt), 32'd0);
    cycle(1'b0, 1'b0);
    check("p3_done_drop", 32'(Done), 32'd0);
    check("p3_width_hold", 32'(Width), 32'd3);

    // 3: clear, then pulses of 2 and 5
    cycle(1'b0, 1'b1);
    check("clr_pcnt", 32'(PulseCnt), 32'd0);
    pulse(2);
    cycle(1'b0, 1'b0);
    check("p2_done", 32'(Done), 32'd1);
    check("p2_width", 32'(Width), 32'd2);
    check("p2_ok", 32'(Ok), 32'd0);
    pulse(5);
    cycle(1'b0, 1'b0);
    check("p5_width", 32'(Width), 32'd5);
    check("p5_ok", 32'(Ok), 32'd0);
    check("p5_pcnt", 32'(PulseCnt), 32'd2);
    check("p5_ecnt", 32'(ErrCnt), 32'd2);

    // 4: stuck-on fault after the 9th high sample
    pulse(8);
    check("st8_stuck", 32'(Stuck), 32'd0);
    cycle(1'b1, 1'b0);
    check("st9_stuck", 32'(Stuck), 32'd1);
    check("st9_done", 32'(Done), 32'd0);
    cycle(1'b1, 1'b1);
    check("st_clr_x1", 32'(Stuck), 32'd1);
    check("st_pcnt_frozen", 32'(PulseCnt), 32'd2);
    cycle(1'b0, 1'b0);
    check("st_x0_noclr", 32'(Stuck), 32'd1);
    check("st_no_done", 32'(Done), 32'd0);
    check("st_width_hold", 32'(Width), 32'd5);
    cycle(1'b0, 1'b1);
    check("st_exit", 32'(Stuck), 32'd0);
    check("st_exit_pcnt", 32'(PulseCnt), 32'd0);
    check("st_exit_ecnt", 32'(ErrCnt), 32'd0);

    // 5: back-to-back 3-cycle pulses with a one-sample gap
    pulse(3);
    cycle(1'b0, 1'b0);
    check("b2b_done1", 32'(Done), 32'd1);
    check("b2b_width1", 32'(Width), 32'd3);
    cycle(1'b1, 1'b0);
    check("b2b_done_gap", 32'(Done), 32'd0);
    pulse(2);
    cycle(1'b0, 1'b0);
    check("b2b_done2", 32'(Done), 32'd1);
    check("b2b_width2", 32'(Width), 32'd3);
    check("b2b_ok2", 32'(Ok), 32'd1);
    check("b2b_pcnt", 32'(PulseCnt), 32'd2);

    // 6: clear on the pulse-end edge
    pulse(4);
    cycle(1'b0, 1'b1);
    check("clrend_done", 32'(Done), 32'd1);
    check("clrend_width", 32'(Width), 32'd4);
    check("clrend_ok", 32'(Ok), 32'd0);
    check("clrend_pcnt", 32'(PulseCnt), 32'd0);
    check("clrend_ecnt", 32'(ErrCnt), 32'd0);
    pulse(3);
    cycle(1'b0, 1'b1);
    check("clrend3_width", 32'(Width), 32'd3);
    check("clrend3_pcnt", 32'(PulseCnt), 32'd0);

    // Counter boundaries: 256 width-1 pulses wrap PulseCnt and saturate ErrCnt
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
    check("wrap_pcnt", 32'(PulseCnt), 32'd0);
    check("sat_ecnt", 32'(ErrCnt), 32'd255);
    check("wrap_width", 32'(Width), 32'd1);
    pulse(1);
    cycle(1'b0, 1'b0);
    check("wrap_pcnt1", 32'(PulseCnt), 32'd1);
    check("sat_ecnt_hold", 32'(ErrCnt), 32'd255);

    // Asynchronous reset mid-pulse
    pulse(2);
    #2;
    Rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge Clk);
    #1;
    check("midrst_done", 32'(Done), 32'd0);
    Rst = 1'b1;
    pulse(2);
    cycle(1'b0, 1'b0);
    check("postrst_done", 32'(Done), 32'd1);
    check("postrst_width", 32'(Width), 32'd2);
    check("postrst_pcnt", 32'(PulseCnt), 32'd1);
    check("postrst_ecnt", 32'(ErrCnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
